filter2d_dbuf_ctrl: RTL and testbench
=====================================

FILTER2D_DBUF_CTRL -- requirements
Module: filter2d_dbuf_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, giving the image side in pixels; one frame is WIDTH*WIDTH pixels.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port ld_req, input, 1 bit: loader level request for a bank to fill.
REQ-005 The block SHALL have port ld_gnt, output, 1 bit: one-cycle grant pulse.
REQ-006 The block SHALL have port ld_bank, output, 1 bit: bank granted; valid with ld_gnt and held until the next grant.
REQ-007 The block SHALL have port ld_done, input, 1 bit: pulse, the bank being filled is complete.
REQ-008 The block SHALL have port op_start, output, 1 bit: one-cycle start strobe to the 2D filter.
REQ-009 The block SHALL have port op_bank, output, 1 bit: bank the filter reads; held stable for the whole frame.
REQ-010 The block SHALL have port pix_strb, input, 1 bit: filter output-pixel strobe.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame's last pixel strobe is seen.
REQ-012 The block SHALL have ports cfg_wr (input, 1), cfg_idx (input, 4) and cfg_data (input, 8): host kernel-coefficient write.
REQ-013 The block SHALL have ports h_write (output, 1), h_idx (output, 4) and h_data (output, 8): the coefficient write to the filter.
REQ-014 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a rejected config write or protocol error.
REQ-015 The block SHALL have port busy, output, 1 bit: high while the op FSM is not IDLE.

Function
REQ-016 Each bank SHALL hold a state of EMPTY, FILLING, FULL or PROC.
REQ-017 Write pointer wr_ptr and read pointer rd_ptr SHALL each be 1 bit, both 0 after reset; wr_ptr SHALL toggle on each accepted ld_done and rd_ptr SHALL toggle on each frame_done (strict ping-pong).
REQ-018 Grant: when ld_req=1, bank[wr_ptr]=EMPTY and no bank is FILLING, the block SHALL pulse ld_gnt, drive ld_bank=wr_ptr on the next cycle and set that bank to FILLING.
REQ-019 An ld_done with a bank FILLING SHALL set that bank to FULL; an ld_done with no bank FILLING SHALL be ignored and SHALL pulse cfg_err.
REQ-020 The op FSM SHALL have states IDLE, RUN and FLUSH.
REQ-021 IDLE->RUN: when bank[rd_ptr]=FULL and there are no dirty shadow entries, the block SHALL pulse op_start for one cycle, register op_bank=rd_ptr and set that bank to PROC.
REQ-022 In RUN, the block SHALL count pix_strb pulses with a 17-bit counter; on the strobe that brings the count to WIDTH*WIDTH it SHALL set the bank to EMPTY, pulse frame_done the next cycle, clear the counter and move to FLUSH if any shadow entry is dirty, else to IDLE.
REQ-023 pix_strb outside RUN SHALL be ignored.
REQ-024 Simultaneous events (ld_done plus frame completion, or grant plus frame completion) SHALL all take effect in the same cycle, since they touch distinct banks.
REQ-025 A bank freed in cycle N SHALL be grantable no earlier than cycle N+1.
REQ-026 Config writes in IDLE SHALL be registered to h_write/h_idx/h_data with 1-cycle latency.
REQ-027 cfg_wr with cfg_idx>8 SHALL be dropped and SHALL pulse cfg_err.
REQ-028 h_write SHALL never be asserted in RUN.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL set both banks EMPTY, both pointers 0, op FSM to IDLE, counter 0 and all shadow dirty bits clear.
REQ-030 On reset, all outputs SHALL go to 0, including during mid-frame or mid-flush, with no frame_done issued.

Configuration
REQ-031 Macro KERNEL_SHADOW_EN defined: cfg_wr during RUN or FLUSH SHALL write a 9-entry shadow (cfg_idx sets its dirty bit; last write wins).
REQ-032 With KERNEL_SHADOW_EN, FLUSH SHALL emit one h_write per dirty entry in ascending idx, one per cycle, clearing each dirty bit, then go to IDLE.
REQ-033 With KERNEL_SHADOW_EN, the next op_start SHALL wait until the flush completes.
REQ-034 Without KERNEL_SHADOW_EN: there SHALL be no shadow storage and no FLUSH state; cfg_wr during RUN SHALL be dropped and SHALL pulse cfg_err.

Verification (WIDTH=4, 16 pixels/frame)
REQ-035 The bench SHALL cover: ld_req from reset -> ld_gnt pulse with ld_bank=0; ld_done -> op_start pulse with op_bank=0; 16 pix_strb -> frame_done pulse, busy falls.
REQ-036 The bench SHALL cover: fill bank0, fill bank1 while frame0 runs -> second grant ld_bank=1 during RUN; after frame_done -> op_start with op_bank=1 within 2 cycles.
REQ-037 The bench SHALL cover: both banks FULL plus ld_req -> no ld_gnt until frame_done frees bank0, then ld_bank=0.
REQ-038 The bench SHALL cover: cfg_wr idx=4 data=0x40 in IDLE -> h_write next cycle with h_idx=4, h_data=0x40; cfg_idx=9 -> cfg_err and no h_write.
REQ-039 The bench SHALL cover: cfg_wr idx=2 then idx=7 during RUN -> with macro, two h_write pulses (idx 2, 7) after frame_done, before the next op_start; without macro, two cfg_err pulses and no h_write.
REQ-040 The bench SHALL cover: reset asserted after 8 pix_strb -> all outputs 0 next cycle, no frame_done; a fresh ld_req then gets ld_bank=0.

Source files
------------

// File: rtl/filter2d_dbuf_ctrl.sv
// Ping-pong bank controller for a 2D filter: loader grants, frame sequencing, kernel writes.
// Define KERNEL_SHADOW_EN to buffer kernel writes made mid-frame and flush them afterwards.
module filter2d_dbuf_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_req,
  output logic       ld_gnt,
  output logic       ld_bank,
  input  logic       ld_done,
  output logic       op_start,
  output logic       op_bank,
  input  logic       pix_strb,
  output logic       frame_done,
  input  logic       cfg_wr,
  input  logic [3:0] cfg_idx,
  input  logic [7:0] cfg_data,
  output logic       h_write,
  output logic [3:0] h_idx,
  output logic [7:0] h_data,
  output logic       cfg_err,
  output logic       busy
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, PROC} bank_t;
`ifdef KERNEL_SHADOW_EN
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} op_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} op_t;
`endif

  localparam logic [16:0] LAST = 17'(WIDTH * WIDTH - 1);

  bank_t       bank_q [2];
  bank_t       bank_d [2];
  op_t         op_q, op_d;
  logic [16:0] cnt_q, cnt_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        ld_gnt_q, ld_gnt_d;
  logic        ld_bank_q, ld_bank_d;
  logic        op_start_q, op_start_d;
  logic        op_bank_q, op_bank_d;
  logic        frame_done_q, frame_done_d;
  logic        h_write_q, h_write_d;
  logic [3:0]  h_idx_q, h_idx_d;
  logic [7:0]  h_data_q, h_data_d;
  logic        cfg_err_q, cfg_err_d;

  logic filling;
  logic idx_ok;
  logic any_dirty;

  assign filling = (bank_q[0] == FILLING) || (bank_q[1] == FILLING);
  assign idx_ok  = cfg_idx <= 4'd8;

`ifdef KERNEL_SHADOW_EN
  logic [7:0] shd_q [9];
  logic [7:0] shd_d [9];
  logic [8:0] dirty_q, dirty_d;
  logic [3:0] flush_sel;
  logic       shd_wr;

  assign any_dirty = |dirty_q;
  assign shd_wr    = cfg_wr && idx_ok && (op_q != IDLE);

  // lowest dirty index goes out first
  always_comb begin
    flush_sel = '0;
    for (int i = 8; i >= 0; i--) begin
      if (dirty_q[i]) flush_sel = 4'(i);
    end
  end
`else
  assign any_dirty = 1'b0;
`endif

  always_comb begin
    bank_d       = bank_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ld_gnt_d     = 1'b0;
    ld_bank_d    = ld_bank_q;
    op_start_d   = 1'b0;
    op_bank_d    = op_bank_q;
    frame_done_d = 1'b0;
    h_write_d    = 1'b0;
    h_idx_d      = h_idx_q;
    h_data_d     = h_data_q;
    cfg_err_d    = 1'b0;
`ifdef KERNEL_SHADOW_EN
    shd_d        = shd_q;
    dirty_d      = dirty_q;
`endif

    if (ld_req && (bank_q[wr_ptr_q] == EMPTY) && !filling) begin
      ld_gnt_d         = 1'b1;
      ld_bank_d        = wr_ptr_q;
      bank_d[wr_ptr_q] = FILLING;
    end

    // only the wr_ptr bank can ever be FILLING
    if (ld_done) begin
      if (filling) begin
        bank_d[wr_ptr_q] = FULL;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (op_q)
      IDLE: begin
        if (cfg_wr) begin
          if (idx_ok) begin
            h_write_d = 1'b1;
            h_idx_d   = cfg_idx;
            h_data_d  = cfg_data;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if ((bank_q[rd_ptr_q] == FULL) && !any_dirty) begin
          op_start_d       = 1'b1;
          op_bank_d        = rd_ptr_q;
          bank_d[rd_ptr_q] = PROC;
          op_d             = RUN;
        end
      end
      RUN: begin
        if (pix_strb) begin
          if (cnt_q == LAST) begin
            cnt_d             = '0;
            frame_done_d      = 1'b1;
            bank_d[op_bank_q] = EMPTY;
            rd_ptr_d          = ~rd_ptr_q;
`ifdef KERNEL_SHADOW_EN
            op_d = (any_dirty || shd_wr) ? FLUSH : IDLE;
`else
            op_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end
      end
`ifdef KERNEL_SHADOW_EN
      FLUSH: begin
        if (any_dirty) begin
          h_write_d          = 1'b1;
          h_idx_d            = flush_sel;
          h_data_d           = shd_q[flush_sel];
          dirty_d[flush_sel] = 1'b0;
        end
      end
`endif
      default: op_d = IDLE;
    endcase

`ifdef KERNEL_SHADOW_EN
    if (shd_wr) begin
      shd_d[cfg_idx]   = cfg_data;
      dirty_d[cfg_idx] = 1'b1;
    end
    if ((op_q != IDLE) && cfg_wr && !idx_ok) cfg_err_d = 1'b1;
    if ((op_q == FLUSH) && (dirty_d == '0)) op_d = IDLE;
`else
    if ((op_q != IDLE) && cfg_wr) cfg_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]    <= EMPTY;
      bank_q[1]    <= EMPTY;
      op_q         <= IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      ld_gnt_q     <= 1'b0;
      ld_bank_q    <= 1'b0;
      op_start_q   <= 1'b0;
      op_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
      h_write_q    <= 1'b0;
      h_idx_q      <= '0;
      h_data_q     <= '0;
      cfg_err_q    <= 1'b0;
`ifdef KERNEL_SHADOW_EN
      shd_q        <= '{default: '0};
      dirty_q      <= '0;
`endif
    end else begin
      bank_q       <= bank_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ld_gnt_q     <= ld_gnt_d;
      ld_bank_q    <= ld_bank_d;
      op_start_q   <= op_start_d;
      op_bank_q    <= op_bank_d;
      frame_done_q <= frame_done_d;
      h_write_q    <= h_write_d;
      h_idx_q      <= h_idx_d;
      h_data_q     <= h_data_d;
      cfg_err_q    <= cfg_err_d;
`ifdef KERNEL_SHADOW_EN
      shd_q        <= shd_d;
      dirty_q      <= dirty_d;
`endif
    end
  end

  assign ld_gnt     = ld_gnt_q;
  assign ld_bank    = ld_bank_q;
  assign op_start   = op_start_q;
  assign op_bank    = op_bank_q;
  assign frame_done = frame_done_q;
  assign h_write    = h_write_q;
  assign h_idx      = h_idx_q;
  assign h_data     = h_data_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = op_q != IDLE;

endmodule

// File: tb/tb_filter2d_dbuf_ctrl.sv
// Bench for filter2d_dbuf_ctrl with WIDTH=4 (16 pixels per frame).
// Expectations follow KERNEL_SHADOW_EN when it is defined.
module tb_filter2d_dbuf_ctrl;

  logic       clk;
  logic       reset;
  logic       ld_req, ld_gnt, ld_bank, ld_done;
  logic       op_start, op_bank, pix_strb, frame_done;
  logic       cfg_wr;
  logic [3:0] cfg_idx;
  logic [7:0] cfg_data;
  logic       h_write;
  logic [3:0] h_idx;
  logic [7:0] h_data;
  logic       cfg_err, busy;

  int checks = 0;
  int errors = 0;

`ifdef KERNEL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  filter2d_dbuf_ctrl #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_req     (ld_req),
    .ld_gnt     (ld_gnt),
    .ld_bank    (ld_bank),
    .ld_done    (ld_done),
    .op_start   (op_start),
    .op_bank    (op_bank),
    .pix_strb   (pix_strb),
    .frame_done (frame_done),
    .cfg_wr     (cfg_wr),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .h_write    (h_write),
    .h_idx      (h_idx),
    .h_data     (h_data),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req, done, strb, wr;
    logic [3:0] idx;
    logic [7:0] data;
    logic       gnt, lbank, start, obank, fdone, hw;
    logic [3:0] hidx;
    logic [7:0] hdata;
    logic       err, bsy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mv(input int rq, dn, st, w, ix, dt,
                              input int g, lb, s, ob, fd, hw,
                              input int hi, hd, er, bs);
    vec_t r;
    r.req   = 1'(rq);
    r.done  = 1'(dn);
    r.strb  = 1'(st);
    r.wr    = 1'(w);
    r.idx   = 4'(ix);
    r.data  = 8'(dt);
    r.gnt   = 1'(g);
    r.lbank = 1'(lb);
    r.start = 1'(s);
    r.obank = 1'(ob);
    r.fdone = 1'(fd);
    r.hw    = 1'(hw);
    r.hidx  = 4'(hi);
    r.hdata = 8'(hd);
    r.err   = 1'(er);
    r.bsy   = 1'(bs);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, dn, st, w,
                       input logic [3:0] ix, input logic [7:0] dt);
    ld_req   = rq;
    ld_done  = dn;
    pix_strb = st;
    cfg_wr   = w;
    cfg_idx  = ix;
    cfg_data = dt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 4'd0, 8'h00);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 4'd0, 8'h00);

    // single-bank walk-through, IDLE config writes and errors
    tv.push_back(mv(0,0,0,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,0));
    tv.push_back(mv(0,0,0,1,4,'h40, 0,0,0,0,0,1,4,'h40,0,0));
    tv.push_back(mv(0,0,0,1,9,'h55, 0,0,0,0,0,0,0,'h00,1,0));
    tv.push_back(mv(0,1,0,0,0,'h00, 0,0,0,0,0,0,0,'h00,1,0));
    tv.push_back(mv(1,0,0,0,0,'h00, 1,0,0,0,0,0,0,'h00,0,0));
    tv.push_back(mv(0,0,0,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,0));
    tv.push_back(mv(0,1,0,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,0));
    tv.push_back(mv(0,0,0,0,0,'h00, 0,0,1,0,0,0,0,'h00,0,1));
    tv.push_back(mv(0,0,0,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,1));
    for (int i = 0; i < 15; i++)
      tv.push_back(mv(0,0,1,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,1));
    tv.push_back(mv(0,0,1,0,0,'h00, 0,0,0,0,1,0,0,'h00,0,0));
    tv.push_back(mv(0,0,1,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,0));
    tv.push_back(mv(0,0,0,0,0,'h00, 0,0,0,0,0,0,0,'h00,0,0));

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].req, tv[i].done, tv[i].strb, tv[i].wr,
            tv[i].idx, tv[i].data);
      step();
      chk($sformatf("v%0d.ld_gnt", i), 32'(ld_gnt), 32'(tv[i].gnt));
      chk($sformatf("v%0d.ld_bank", i), 32'(ld_bank), 32'(tv[i].lbank));
      chk($sformatf("v%0d.op_start", i), 32'(op_start), 32'(tv[i].start));
      chk($sformatf("v%0d.op_bank", i), 32'(op_bank), 32'(tv[i].obank));
      chk($sformatf("v%0d.frame_done", i), 32'(frame_done), 32'(tv[i].fdone));
      chk($sformatf("v%0d.h_write", i), 32'(h_write), 32'(tv[i].hw));
      if (tv[i].hw) begin
        chk($sformatf("v%0d.h_idx", i), 32'(h_idx), 32'(tv[i].hidx));
        chk($sformatf("v%0d.h_data", i), 32'(h_data), 32'(tv[i].hdata));
      end
      chk($sformatf("v%0d.cfg_err", i), 32'(cfg_err), 32'(tv[i].err));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tv[i].bsy));
    end

    // ping-pong: second bank filled during frame 0, loader blocked
    do_reset();
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    chk("pp.gnt0", 32'(ld_gnt), 32'd1);
    chk("pp.bank0", 32'(ld_bank), 32'd0);
    drive(1, 1, 0, 0, 4'd0, 8'h00); step();
    chk("pp.nogrant_filling", 32'(ld_gnt), 32'd0);
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    chk("pp.gnt1", 32'(ld_gnt), 32'd1);
    chk("pp.bank1", 32'(ld_bank), 32'd1);
    chk("pp.start0", 32'(op_start), 32'd1);
    chk("pp.obank0", 32'(op_bank), 32'd0);
    chk("pp.busy_gnt", 32'(busy), 32'd1);
    drive(1, 1, 0, 0, 4'd0, 8'h00); step();
    chk("pp.done1_noerr", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 0, 4'd0, 8'h00); step();
      chk($sformatf("pp.blocked%0d", i), 32'(ld_gnt), 32'd0);
      chk($sformatf("pp.fdone%0d", i), 32'(frame_done), 32'(i == 15));
    end
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    chk("pp.start1", 32'(op_start), 32'd1);
    chk("pp.obank1", 32'(op_bank), 32'd1);
    chk("pp.regrant", 32'(ld_gnt), 32'd1);
    chk("pp.regrant_bank0", 32'(ld_bank), 32'd0);
    drive(0, 0, 0, 0, 4'd0, 8'h00); step();
    chk("pp.gnt_pulse", 32'(ld_gnt), 32'd0);
    chk("pp.bank_hold", 32'(ld_bank), 32'd0);
    chk("pp.obank_hold", 32'(op_bank), 32'd1);
    chk("pp.busy1", 32'(busy), 32'd1);

    // kernel writes during RUN
    do_reset();
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    drive(0, 1, 0, 0, 4'd0, 8'h00); step();
    drive(0, 0, 0, 0, 4'd0, 8'h00); step();
    chk("kr.start0", 32'(op_start), 32'd1);
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    chk("kr.gnt1", 32'(ld_gnt), 32'd1);
    drive(0, 1, 0, 0, 4'd0, 8'h00); step();
    drive(0, 0, 0, 1, 4'd2, 8'h22); step();
    chk("kr.err_idx2", 32'(cfg_err), 32'(!SHADOW));
    chk("kr.nohw_idx2", 32'(h_write), 32'd0);
    drive(0, 0, 0, 1, 4'd7, 8'h77); step();
    chk("kr.err_idx7", 32'(cfg_err), 32'(!SHADOW));
    chk("kr.nohw_idx7", 32'(h_write), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 4'd0, 8'h00); step();
      chk($sformatf("kr.run_nohw%0d", i), 32'(h_write), 32'd0);
    end
    chk("kr.fdone", 32'(frame_done), 32'd1);
    chk("kr.busy_end", 32'(busy), 32'(SHADOW));
    drive(0, 0, 0, 0, 4'd0, 8'h00);
`ifdef KERNEL_SHADOW_EN
    step();
    chk("kr.fl1_hw", 32'(h_write), 32'd1);
    chk("kr.fl1_idx", 32'(h_idx), 32'd2);
    chk("kr.fl1_data", 32'(h_data), 32'h22);
    chk("kr.fl1_nostart", 32'(op_start), 32'd0);
    step();
    chk("kr.fl2_hw", 32'(h_write), 32'd1);
    chk("kr.fl2_idx", 32'(h_idx), 32'd7);
    chk("kr.fl2_data", 32'(h_data), 32'h77);
    chk("kr.fl2_nostart", 32'(op_start), 32'd0);
    chk("kr.fl2_idle", 32'(busy), 32'd0);
    step();
    chk("kr.post_hw", 32'(h_write), 32'd0);
    chk("kr.start1", 32'(op_start), 32'd1);
    chk("kr.obank1", 32'(op_bank), 32'd1);
`else
    step();
    chk("kr.start1", 32'(op_start), 32'd1);
    chk("kr.obank1", 32'(op_bank), 32'd1);
    chk("kr.post_hw1", 32'(h_write), 32'd0);
    step();
    chk("kr.post_hw2", 32'(h_write), 32'd0);
    step();
    chk("kr.post_hw3", 32'(h_write), 32'd0);
`endif

    // reset mid-frame
    do_reset();
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    drive(0, 1, 0, 0, 4'd0, 8'h00); step();
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    chk("rs.start", 32'(op_start), 32'd1);
    chk("rs.bank1", 32'(ld_bank), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 4'd0, 8'h00); step();
    end
    chk("rs.busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    drive(0, 0, 1, 0, 4'd0, 8'h00); step();
    chk("rs.gnt", 32'(ld_gnt), 32'd0);
    chk("rs.ld_bank", 32'(ld_bank), 32'd0);
    chk("rs.start0", 32'(op_start), 32'd0);
    chk("rs.op_bank", 32'(op_bank), 32'd0);
    chk("rs.fdone", 32'(frame_done), 32'd0);
    chk("rs.hw", 32'(h_write), 32'd0);
    chk("rs.h_idx", 32'(h_idx), 32'd0);
    chk("rs.h_data", 32'(h_data), 32'd0);
    chk("rs.err", 32'(cfg_err), 32'd0);
    chk("rs.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 4'd0, 8'h00); step();
      chk($sformatf("rs.no_fdone%0d", i), 32'(frame_done), 32'd0);
    end
    drive(1, 0, 0, 0, 4'd0, 8'h00); step();
    chk("rs.regnt", 32'(ld_gnt), 32'd1);
    chk("rs.regnt_bank", 32'(ld_bank), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
